// File: rtl/seq_pipe_ctrl_if.sv
// Valid/ready stream bundle used on both sides of seq_pipe_ctrl.
// master drives valid/data, slave drives ready.
interface seq_pipe_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/seq_pipe_ctrl.sv
// Three-stage valid/ready register pipeline with bubble collapse,
// synchronous flush and a built-in sequence generator feeding S0.
module seq_pipe_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_pipe_ctrl_if.slave   prod,
    seq_pipe_ctrl_if.master  cons,
    input  logic             gen_en,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] out_count
);

    logic [WIDTH-1:0] d0, d1, d2;
    logic             v0, v1, v2;
    logic [WIDTH-1:0] gen_cnt;
    logic [WIDTH-1:0] src_data;
    logic             src_valid;
    logic             load0, load1, load2;

    // A stage may load when it is empty or the stage ahead is moving.
    always_comb begin
        load2     = !v2 | cons.ready;
        load1     = !v1 | load2;
        load0     = !v0 | load1;
        src_valid = gen_en ? 1'b1 : prod.valid;
        src_data  = gen_en ? gen_cnt : prod.data;
    end

    assign prod.ready = load0 & !flush & !gen_en;
    assign cons.valid = v2;
    assign cons.data  = d2;
    assign occupancy  = 2'(v0) + 2'(v1) + 2'(v2);

    always_ff @(posedge clk) begin
        if (rst) begin
            d0        <= '0;
            d1        <= '0;
            d2        <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            gen_cnt   <= '0;
            out_count <= '0;
        end else begin
            if (load2) d2 <= d1;
            if (load1) d1 <= d0;
            if (load0) d0 <= src_data;
            if (flush) begin
                v0 <= 1'b0;
                v1 <= 1'b0;
                v2 <= 1'b0;
            end else begin
                if (load2) v2 <= v1;
                if (load1) v1 <= v0;
                if (load0) v0 <= src_valid;
            end
            // A transfer in a flush cycle still completes.
            if (v2 && cons.ready) out_count <= out_count + 1'b1;
            if (gen_en && load0 && !flush) gen_cnt <= gen_cnt + 1'b1;
        end
    end

endmodule
